// File: rtl/seq_detect.sv
// Serial pattern detector (Moore FSM). State k counts pattern bits matched so far;
// state PAT_LEN is DETECT and drives out high for one cycle per hit.
module seq_detect #(
  parameter int unsigned            PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]     PATTERN = 4'b1011,
  parameter bit                     OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic Data_in,
  output logic out
);

  localparam int unsigned SW = $clog2(PAT_LEN + 1);

  localparam logic [SW-1:0] S_MATCH0 = '0;
  localparam logic [SW-1:0] S_DETECT = SW'(PAT_LEN);

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then b);
  // a full match of the extended string yields k+1.
  function automatic int unsigned next_fn(input int unsigned k, input logic b);
    int unsigned best;
    int unsigned idx;
    logic        ok;
    logic        sbit;
    best = 0;
    for (int unsigned len = 1; len <= PAT_LEN; len++) begin
      if (len <= k + 1) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < len; j++) begin
          idx = k + 1 - len + j;
          if (idx == k) sbit = b;
          else          sbit = PATTERN[PAT_LEN-1-idx];
          if (sbit != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
        end
        if (ok) best = len;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] nxt0 [0:PAT_LEN];
  logic [SW-1:0] nxt1 [0:PAT_LEN];

  for (genvar k = 0; k <= PAT_LEN; k++) begin : g_tbl
    if (k == PAT_LEN && !OVERLAP) begin : g_restart
      // Non-overlapping: only a fresh pattern MSB survives a hit.
      assign nxt0[k] = (PATTERN[PAT_LEN-1] == 1'b0) ? SW'(1) : S_MATCH0;
      assign nxt1[k] = (PATTERN[PAT_LEN-1] == 1'b1) ? SW'(1) : S_MATCH0;
    end else begin : g_kmp
      assign nxt0[k] = SW'(next_fn(k, 1'b0));
      assign nxt1[k] = SW'(next_fn(k, 1'b1));
    end
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;

  always_comb begin
    state_d = S_MATCH0;
    for (int unsigned k = 0; k <= PAT_LEN; k++) begin
      if (state_q == SW'(k)) state_d = Data_in ? nxt1[k] : nxt0[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_MATCH0;
    else      state_q <= state_d;
  end

  assign out = (state_q == S_DETECT);

endmodule

// File: tb/tb_seq_detect.sv
// Directed-vector bench: default 1011 overlapping, 1011 non-overlapping,
// and a 2-bit pattern 11 for back-to-back hits, all fed the same stream.
module tb_seq_detect;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic Data_in = 1'b0;
  logic out_ov, out_nov, out_11;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  seq_detect dut_ov (
    .clk(clk), .rst(rst), .Data_in(Data_in), .out(out_ov)
  );

  seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_nov (
    .clk(clk), .rst(rst), .Data_in(Data_in), .out(out_nov)
  );

  seq_detect #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)) dut_11 (
    .clk(clk), .rst(rst), .Data_in(Data_in), .out(out_11)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // {rst, Data_in, exp_ov, exp_nov, exp_11} per clock edge
  localparam int unsigned NV = 40;
  logic [4:0] vec [NV];

  initial begin
    vec[0]  = 5'b0_1_000;  // reset, data toggling
    vec[1]  = 5'b0_0_000;
    vec[2]  = 5'b1_1_000;  // single hit 1011
    vec[3]  = 5'b1_0_000;
    vec[4]  = 5'b1_1_000;
    vec[5]  = 5'b1_1_111;
    vec[6]  = 5'b0_1_000;  // overlap stream 101101101
    vec[7]  = 5'b1_1_000;
    vec[8]  = 5'b1_0_000;
    vec[9]  = 5'b1_1_000;
    vec[10] = 5'b1_1_111;
    vec[11] = 5'b1_0_000;
    vec[12] = 5'b1_1_000;
    vec[13] = 5'b1_1_101;
    vec[14] = 5'b1_0_000;
    vec[15] = 5'b1_1_000;
    vec[16] = 5'b0_0_000;  // near miss 11011, then extra 1
    vec[17] = 5'b1_1_000;
    vec[18] = 5'b1_1_001;
    vec[19] = 5'b1_0_000;
    vec[20] = 5'b1_1_000;
    vec[21] = 5'b1_1_111;
    vec[22] = 5'b1_1_001;
    vec[23] = 5'b0_1_000;  // near miss 1001011
    vec[24] = 5'b1_1_000;
    vec[25] = 5'b1_0_000;
    vec[26] = 5'b1_0_000;
    vec[27] = 5'b1_1_000;
    vec[28] = 5'b1_0_000;
    vec[29] = 5'b1_1_000;
    vec[30] = 5'b1_1_111;
    vec[31] = 5'b0_0_000;  // mid-sequence reset
    vec[32] = 5'b1_1_000;
    vec[33] = 5'b1_0_000;
    vec[34] = 5'b1_1_000;
    vec[35] = 5'b0_1_000;
    vec[36] = 5'b1_1_000;
    vec[37] = 5'b1_0_000;
    vec[38] = 5'b1_1_000;
    vec[39] = 5'b1_1_111;

    for (int unsigned i = 0; i < NV; i++) begin
      @(negedge clk);
      rst     = vec[i][4];
      Data_in = vec[i][3];
      @(posedge clk);
      #1;
      check($sformatf("ov[%0d]", i),  out_ov,  vec[i][2]);
      check($sformatf("nov[%0d]", i), out_nov, vec[i][1]);
      check($sformatf("p11[%0d]", i), out_11,  vec[i][0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
